// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island definitions: period encoding for the TMDS encoders and island timing.
// Used by hdmi_island_scheduler for its period timers and blank-room checks.
package hdmi_pkg;

  typedef enum logic [1:0] {
    P_CTRL     = 2'd0,
    P_PREAMBLE = 2'd1,
    P_GUARD    = 2'd2,
    P_DATA     = 2'd3
  } period_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PKT_LEN      = 32;

  // Cycles from the first preamble cycle to the last trailing guard cycle for k packets.
  function automatic int min_island_len(input int k);
    return PREAMBLE_LEN + 2 * GUARD_LEN + k * PKT_LEN;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above the pointer wins, wrapping around.
// The pointer only moves past the winner when the caller commits the decision with advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         pix_clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic         any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [N-1:0]  w_upper;

  assign any = |req;

  always_comb begin
    w_upper = '0;
    for (int i = 0; i < N; i++) begin
      w_upper[i] = req[i] && (i >= int'(r_ptr));
    end
    // Scan downwards so the lowest qualifying index is the one left standing.
    w_win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_upper != '0) begin
        if (w_upper[i]) w_win = PW'(i);
      end else if (req[i]) begin
        w_win = PW'(i);
      end
    end
    gnt = '0;
    if (any) gnt[w_win] = 1'b1;
  end

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance && any) begin
      r_ptr <= (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Sequences HDMI data islands inside blanking and shares the island between N_REQ packet sources.
// Define HDMI_ISLAND_STATS_EN to add the island_cnt / pkt_cnt statistics outputs.
module hdmi_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_PKTS  = 18,
  parameter int CTRL_LEAD = 12,
  parameter int CTRL_TAIL = 12,
  parameter int CW        = 12
) (
  input  logic             pix_clk,
  input  logic             reset,
  input  logic             blank,
  input  logic [CW-1:0]    blank_left,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             null_pkt,
  output logic [4:0]       pkt_idx,
  output logic [1:0]       mode,
  output logic             busy,
  output logic             overrun
`ifdef HDMI_ISLAND_STATS_EN
  ,
  output logic [15:0]      island_cnt,
  output logic [15:0]      pkt_cnt
`endif
);

  // state       | meaning
  // S_IDLE      | control period; waits for lead time, a request and room left in the blank
  // S_PREAMBLE  | data-island preamble
  // S_LGUARD    | leading guard band; its last cycle arbitrates the first packet
  // S_DATA      | packet words; word 31 arbitrates the next packet or closes the island
  // S_TGUARD    | trailing guard band, then back to idle
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_LGUARD   = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_TGUARD   = 3'd4;

  localparam int LW        = (CTRL_LEAD > 0) ? $clog2(CTRL_LEAD + 1) : 1;
  localparam int NW        = $clog2(MAX_PKTS + 1);
  localparam int START_MIN = min_island_len(1) + CTRL_TAIL;
  localparam int CONT_MIN  = 1 + PKT_LEN + GUARD_LEN + CTRL_TAIL;

  logic [2:0]       r_state;
  logic [2:0]       r_tmr;
  logic [LW-1:0]    r_lead;
  logic [NW-1:0]    r_npkt;
  logic [N_REQ-1:0] r_grant;
  logic             r_null;
  logic [4:0]       r_pkt_idx;
  period_t          r_mode;
  logic             r_busy;
  logic             r_overrun;

  logic             w_active;
  logic             w_start;
  logic             w_last_word;
  logic             w_cont;
  logic             w_arb_slot;
  logic             w_advance;
  logic             w_any;
  logic [N_REQ-1:0] w_gnt;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .pix_clk (pix_clk),
    .reset   (reset),
    .req     (req),
    .advance (w_advance),
    .gnt     (w_gnt),
    .any     (w_any)
  );

  assign w_active    = (r_state != S_IDLE);
  assign w_start     = blank && w_any && (r_lead == LW'(CTRL_LEAD)) &&
                       (blank_left >= CW'(START_MIN));
  assign w_last_word = (r_state == S_DATA) && (r_pkt_idx == 5'(PKT_LEN - 1));
  assign w_cont      = w_any && (r_npkt < NW'(MAX_PKTS)) && (blank_left >= CW'(CONT_MIN));
  assign w_arb_slot  = ((r_state == S_LGUARD) && (r_tmr == '0)) || (w_last_word && w_cont);
  // A blank drop on the arbitration cycle aborts the island, so the pointer must not move.
  assign w_advance   = w_arb_slot && blank;

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_lead    <= '0;
      r_npkt    <= '0;
      r_grant   <= '0;
      r_null    <= 1'b0;
      r_pkt_idx <= '0;
      r_mode    <= P_CTRL;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_lead  <= !blank ? '0 : ((r_lead == LW'(CTRL_LEAD)) ? r_lead : r_lead + 1'b1);
      r_grant <= '0;
      if (w_active && !blank) begin
        r_state   <= S_IDLE;
        r_mode    <= P_CTRL;
        r_busy    <= 1'b0;
        r_null    <= 1'b0;
        r_pkt_idx <= '0;
        r_overrun <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state <= S_PREAMBLE;
              r_tmr   <= 3'(PREAMBLE_LEN - 1);
              r_mode  <= P_PREAMBLE;
              r_busy  <= 1'b1;
              r_npkt  <= '0;
            end
          end
          S_PREAMBLE: begin
            if (r_tmr == '0) begin
              r_state <= S_LGUARD;
              r_tmr   <= 3'(GUARD_LEN - 1);
              r_mode  <= P_GUARD;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          S_LGUARD: begin
            if (r_tmr == '0) begin
              r_state   <= S_DATA;
              r_mode    <= P_DATA;
              r_pkt_idx <= '0;
              r_grant   <= w_gnt;
              r_null    <= !w_any;
              r_npkt    <= NW'(1);
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          S_DATA: begin
            if (w_last_word) begin
              r_pkt_idx <= '0;
              if (w_cont) begin
                r_grant <= w_gnt;
                r_null  <= 1'b0;
                r_npkt  <= r_npkt + 1'b1;
              end else begin
                r_state <= S_TGUARD;
                r_tmr   <= 3'(GUARD_LEN - 1);
                r_mode  <= P_GUARD;
                r_null  <= 1'b0;
              end
            end else begin
              r_pkt_idx <= r_pkt_idx + 1'b1;
            end
          end
          S_TGUARD: begin
            if (r_tmr == '0) begin
              r_state <= S_IDLE;
              r_mode  <= P_CTRL;
              r_busy  <= 1'b0;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_mode  <= P_CTRL;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign grant    = r_grant;
  assign null_pkt = r_null;
  assign pkt_idx  = r_pkt_idx;
  assign mode     = r_mode;
  assign busy     = r_busy;
  assign overrun  = r_overrun;

`ifdef HDMI_ISLAND_STATS_EN
  logic [15:0] r_island_cnt;
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      r_island_cnt <= '0;
      r_pkt_cnt    <= '0;
    end else begin
      // Aborted islands never reach the end of the trailing guard, so they are not counted.
      if ((r_state == S_TGUARD) && (r_tmr == '0) && blank) r_island_cnt <= r_island_cnt + 1'b1;
      if (w_advance && w_any && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign island_cnt = r_island_cnt;
  assign pkt_cnt    = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Bench for hdmi_island_scheduler: start-condition table, directed island sequences,
// then random blanking lines checked cycle by cycle against an island-timeline model.
module tb_hdmi_island_scheduler;

  localparam int N          = 4;
  localparam int MAXP       = 18;
  localparam int LEAD       = 12;
  localparam int START_NEED = 8 + 2 + 32 + 2 + 12;
  localparam int CONT_NEED  = 1 + 32 + 2 + 12;

  logic        pix_clk = 1'b0;
  logic        reset;
  logic        blank;
  logic [11:0] blank_left;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        null_pkt;
  logic [4:0]  pkt_idx;
  logic [1:0]  mode;
  logic        busy;
  logic        overrun;
`ifdef HDMI_ISLAND_STATS_EN
  logic [15:0] island_cnt;
  logic [15:0] pkt_cnt;
`endif

  always #5 pix_clk = ~pix_clk;

  hdmi_island_scheduler dut (
    .pix_clk    (pix_clk),
    .reset      (reset),
    .blank      (blank),
    .blank_left (blank_left),
    .req        (req),
    .grant      (grant),
    .null_pkt   (null_pkt),
    .pkt_idx    (pkt_idx),
    .mode       (mode),
    .busy       (busy),
    .overrun    (overrun)
`ifdef HDMI_ISLAND_STATS_EN
    ,
    .island_cnt (island_cnt),
    .pkt_cnt    (pkt_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Island model: an island is a timeline of positions from its first preamble cycle.
  // 0..7 preamble, 8..9 guard, 10..dend-1 packets, dend..dend+1 trailing guard.
  bit       m_isl;
  int       m_pos;
  int       m_dend;
  int       m_npk;
  int       m_ptr;
  int       m_lead;
  bit       m_ovr;
  bit [3:0] m_gnt;
  bit       m_null;
  int       m_icnt;
  int       m_pcnt;

  task automatic model_reset();
    m_isl = 0; m_pos = 0; m_dend = 10; m_npk = 0; m_ptr = 0; m_lead = 0;
    m_ovr = 0; m_gnt = '0; m_null = 0; m_icnt = 0; m_pcnt = 0;
  endtask

  function automatic int exp_mode();
    if (!m_isl) return 0;
    if (m_pos < 8) return 1;
    if (m_pos < 10) return 2;
    if (m_pos < m_dend) return 3;
    return 2;
  endfunction

  function automatic int exp_idx();
    if (m_isl && m_pos >= 10 && m_pos < m_dend) return (m_pos - 10) % 32;
    return 0;
  endfunction

  task automatic model_step(input bit b, input int bl, input bit [3:0] rq);
    int  nlead;
    bit  arb;
    bit  found;
    int  w;
    nlead = b ? ((m_lead < LEAD) ? m_lead + 1 : LEAD) : 0;
    arb   = 0;
    m_gnt = '0;
    if (m_isl && !b) begin
      m_isl = 0; m_ovr = 1; m_null = 0;
    end else if (!m_isl) begin
      if (b && rq != 0 && m_lead == LEAD && bl >= START_NEED) begin
        m_isl = 1; m_pos = 0; m_dend = 10; m_npk = 0;
      end
    end else begin
      if (m_pos == 9) arb = 1;
      else if (m_pos == m_dend - 1 && rq != 0 && m_npk < MAXP && bl >= CONT_NEED) arb = 1;
      if (arb) begin
        m_dend = m_pos + 1 + 32;
        m_npk++;
        m_null = (rq == 0);
        found = 0;
        for (int k = 0; k < N; k++) begin
          w = (m_ptr + k) % N;
          if (!found && rq[w]) begin
            found = 1;
            m_gnt[w] = 1'b1;
            m_ptr = (w + 1) % N;
            if (m_pcnt < 65535) m_pcnt++;
          end
        end
      end else if (m_pos == m_dend - 1) begin
        m_null = 0;
      end
      if (m_pos == m_dend + 1) begin
        m_isl = 0;
        m_icnt = (m_icnt + 1) % 65536;
      end else begin
        m_pos++;
      end
    end
    m_lead = nlead;
  endtask

  task automatic compare_all();
    chk("mode", int'(mode), exp_mode());
    chk("pkt_idx", int'(pkt_idx), exp_idx());
    chk("busy", int'(busy), int'(m_isl));
    chk("null_pkt", int'(null_pkt), int'(m_null));
    chk("grant", int'(grant), int'(m_gnt));
    chk("overrun", int'(overrun), int'(m_ovr));
`ifdef HDMI_ISLAND_STATS_EN
    chk("island_cnt", int'(island_cnt), m_icnt);
    chk("pkt_cnt", int'(pkt_cnt), m_pcnt);
`endif
  endtask

  task automatic cyc();
    model_step(blank, int'(blank_left), req);
    @(posedge pix_clk);
    #1;
    compare_all();
  endtask

  task automatic step1();
    cyc();
    if (blank && blank_left > 1) blank_left = blank_left - 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step1();
  endtask

  task automatic do_reset();
    reset = 1'b1; blank = 1'b0; blank_left = '0; req = '0;
    model_reset();
    repeat (2) @(posedge pix_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rnd_req();
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (m_gnt[i] || $urandom_range(0, 99) == 0) req[i] = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        req[i] = 1'b1;
      end
    end
  endtask

  // Held requests from blank cycle 1 with blank_left=bl0 at cycle 13; returns granted indices.
  task automatic multi_island(input int bl0, input string tag);
    int gq[$];
    int ndata;
    int exp_n;
    bit seen;
    bit done;
    do_reset();
    blank = 1'b1; blank_left = 12'(bl0 + 12);
    run(12);
    req = 4'hF;
    ndata = 0; seen = 0; done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      step1();
      if (busy) seen = 1;
      if (mode == 2'd3) ndata++;
      for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
      if (seen && !busy) done = 1;
    end
    exp_n = 1;
    while (exp_n < MAXP && bl0 - 42 - 32 * (exp_n - 1) >= CONT_NEED) exp_n++;
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_count"}, gq.size(), exp_n);
    chk({tag, "_data_cycles"}, ndata, 32 * exp_n);
    for (int i = 0; i < gq.size() && i < exp_n; i++) chk({tag, "_order"}, gq[i], i % N);
  endtask

  typedef struct {
    int       lead_cyc;
    int       bl;
    bit [3:0] rq;
    int       exp_mode;
  } start_vec_t;

  start_vec_t vecs[6];

  initial begin
    int seq[$];
    int gpos;
    int gcnt;
    int ncnt;
    int gval;
    bit hit;
    int len;

    vecs[0] = '{13, 56,   4'b0100, 1};
    vecs[1] = '{13, 55,   4'b0100, 0};
    vecs[2] = '{13, 200,  4'b0000, 0};
    vecs[3] = '{12, 200,  4'b0100, 0};
    vecs[4] = '{13, 4095, 4'b0001, 1};
    vecs[5] = '{20, 56,   4'b1000, 1};

    do_reset();
    chk("rst_mode", int'(mode), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_null", int'(null_pkt), 0);
    chk("rst_idx", int'(pkt_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Start-condition table: lead time, room in the blank and pending requests.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      blank = 1'b1; blank_left = 12'd300;
      run(vecs[v].lead_cyc - 1);
      blank_left = 12'(vecs[v].bl);
      req = vecs[v].rq;
      step1();
      chk($sformatf("start_vec%0d", v), int'(mode), vecs[v].exp_mode);
    end

    // Single source, dropped after its grant: one packet island.
    do_reset();
    blank = 1'b1; blank_left = 12'd212;
    run(12);
    req = 4'b0100;
    gpos = -1; gcnt = 0;
    for (int c = 0; c < 80; c++) begin
      step1();
      seq.push_back(int'(mode));
      if (grant != 0) begin
        gcnt++; gpos = c;
        chk("single_grant_val", int'(grant), 4);
        req = '0;
      end
    end
    for (int c = 0; c < 80; c++) begin
      int e;
      e = (c < 8) ? 1 : (c < 10) ? 2 : (c < 42) ? 3 : (c < 44) ? 2 : 0;
      chk($sformatf("single_mode_c%0d", c), seq[c], e);
    end
    chk("single_grant_pos", gpos, 10);
    chk("single_grant_cnt", gcnt, 1);

    // All sources held: rotation, blank_left limit, then the packet-count limit.
    multi_island(400, "multi400");
    multi_island(4000, "multi4000");

    // Request withdrawn before arbitration: null packet, pointer untouched.
    do_reset();
    blank = 1'b1; blank_left = 12'd312;
    run(12);
    req = 4'b0010;
    run(4);
    req = '0;
    ncnt = 0; gcnt = 0; hit = 0;
    for (int c = 0; c < 80 && !hit; c++) begin
      step1();
      if (null_pkt) ncnt++;
      if (grant != 0) gcnt++;
      if (!busy) hit = 1;
    end
    chk("null_island_end", int'(hit), 1);
    chk("null_cycles", ncnt, 32);
    chk("null_grants", gcnt, 0);
    req = 4'hF;
    gval = 0; hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      step1();
      if (grant != 0) begin gval = int'(grant); hit = 1; req = '0; end
    end
    chk("null_ptr_kept", gval, 1);
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      step1();
      if (!busy) hit = 1;
    end
    chk("null_second_end", int'(hit), 1);

    // Blank falls mid-packet: overrun, immediate return to control.
    do_reset();
    blank = 1'b1; blank_left = 12'd312;
    run(12);
    req = 4'b0001;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      step1();
      if (grant != 0) req = '0;
      if (mode == 2'd3 && pkt_idx == 5'd10) hit = 1;
    end
    chk("ovr_reached_idx10", int'(hit), 1);
    blank = 1'b0; blank_left = '0;
    step1();
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_mode_ctrl", int'(mode), 0);
    chk("ovr_busy_low", int'(busy), 0);
    chk("ovr_no_grant", int'(grant), 0);
    run(5);
    blank = 1'b1; blank_left = 12'd300;
    run(30);
    chk("ovr_sticky", int'(overrun), 1);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    blank = 1'b1; blank_left = 12'd312;
    run(12);
    req = 4'b0001;
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      step1();
      if (grant != 0) req = '0;
      if (mode == 2'd3 && pkt_idx == 5'd5) hit = 1;
    end
    chk("arst_reached_data", int'(hit), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_mode", int'(mode), 0);
    chk("arst_grant", int'(grant), 0);
    chk("arst_null", int'(null_pkt), 0);
    chk("arst_idx", int'(pkt_idx), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overrun", int'(overrun), 0);
`ifdef HDMI_ISLAND_STATS_EN
    chk("arst_island_cnt", int'(island_cnt), 0);
    chk("arst_pkt_cnt", int'(pkt_cnt), 0);
`endif
    do_reset();

    // Random blanking lines with randomly arriving and withdrawn requests.
    for (int line = 0; line < 30; line++) begin
      blank = 1'b0; blank_left = '0;
      len = int'($urandom_range(5, 30));
      for (int k = 0; k < len; k++) begin rnd_req(); cyc(); end
      len = int'($urandom_range(40, 900));
      blank = 1'b1;
      for (int k = len; k >= 1; k--) begin
        blank_left = 12'(k);
        rnd_req();
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
